// File: rtl/btb_update_arbiter.sv
// Arbitrates the single BTB / direction-predictor port between fetch lookups and buffered CTI updates.
// Optional BTB_UPD_BYPASS_EN: an update arriving while the FIFO is empty and fetch is idle is written in the same cycle.
module btb_update_arbiter #(
  parameter int SIZE_PC      = 32,
  parameter int BRANCH_TYPE  = 2,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   updateEn_i,
  input  logic [SIZE_PC-1:0]     updatePC_i,
  input  logic [SIZE_PC-1:0]     updateTargetAddr_i,
  input  logic [BRANCH_TYPE-1:0] updateCtrlType_i,
  input  logic                   updateDir_i,
  input  logic                   fetchReq_i,
  input  logic [SIZE_PC-1:0]     fetchPC_i,
  output logic                   fetchGrant_o,
  output logic                   btbRdEn_o,
  output logic [SIZE_PC-1:0]     btbRdPC_o,
  output logic                   btbWrEn_o,
  output logic                   bpWrEn_o,
  output logic [SIZE_PC-1:0]     wrPC_o,
  output logic [SIZE_PC-1:0]     wrTarget_o,
  output logic [BRANCH_TYPE-1:0] wrCtrlType_o,
  output logic                   wrDir_o,
  output logic                   updFull_o,
  output logic                   updDrop_o,
  output logic [$clog2(QDEPTH):0] updCount_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BRANCH_TYPE-1:0] TYPE_COND = {BRANCH_TYPE{1'b1}};

  logic [SIZE_PC-1:0]     pc_mem   [QDEPTH];
  logic [SIZE_PC-1:0]     tgt_mem  [QDEPTH];
  logic [BRANCH_TYPE-1:0] type_mem [QDEPTH];
  logic                   dir_mem  [QDEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic empty, full, force_upd, service, bypass, enq, deq, wr_act;
  logic [SIZE_PC-1:0]     src_pc, src_tgt;
  logic [BRANCH_TYPE-1:0] src_type;
  logic                   src_dir;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(QDEPTH));
  assign force_upd = ~empty & (full | (starve_q == SW'(STARVE_LIMIT)));
  assign service   = ~empty & (~fetchReq_i | force_upd);

`ifdef BTB_UPD_BYPASS_EN
  assign bypass = empty & updateEn_i & ~fetchReq_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq = service;
  // A full FIFO always forces a dequeue, so the drop path only guards against future arbitration changes.
  assign enq = updateEn_i & ~bypass & (~full | deq);

  always_comb begin
    src_pc   = pc_mem[rd_ptr_q];
    src_tgt  = tgt_mem[rd_ptr_q];
    src_type = type_mem[rd_ptr_q];
    src_dir  = dir_mem[rd_ptr_q];
    if (bypass) begin
      src_pc   = updatePC_i;
      src_tgt  = updateTargetAddr_i;
      src_type = updateCtrlType_i;
      src_dir  = updateDir_i;
    end
  end

  // Outputs are held low while reset is asserted, regardless of fetch activity.
  assign wr_act = reset & (service | bypass);

  always_comb begin
    fetchGrant_o = reset & fetchReq_i & ~service;
    btbRdEn_o    = fetchGrant_o;
    btbRdPC_o    = fetchGrant_o ? fetchPC_i : '0;
    btbWrEn_o    = wr_act & ((src_type != TYPE_COND) | src_dir);
    bpWrEn_o     = wr_act & (src_type == TYPE_COND);
    wrPC_o       = wr_act ? src_pc : '0;
    wrTarget_o   = wr_act ? src_tgt : '0;
    wrCtrlType_o = wr_act ? src_type : '0;
    wrDir_o      = wr_act & src_dir;
    updDrop_o    = reset & updateEn_i & ~bypass & full & ~deq;
    updFull_o    = full;
    updCount_o   = count_q;
  end

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || service)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= updatePC_i;
      tgt_mem[wr_ptr_q]  <= updateTargetAddr_i;
      type_mem[wr_ptr_q] <= updateCtrlType_i;
      dir_mem[wr_ptr_q]  <= updateDir_i;
    end
  end

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Scoreboard bench for btb_update_arbiter: expected writes are queued at enqueue and popped when the array write appears.
module tb_btb_update_arbiter;

`ifdef BTB_UPD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        updateEn;
  logic [31:0] updatePC, updateTgt;
  logic [1:0]  updateType;
  logic        updateDir;
  logic        fetchReq;
  logic [31:0] fetchPC;
  logic        fetchGrant, btbRdEn, btbWrEn, bpWrEn, wrDir, updFull, updDrop;
  logic [31:0] btbRdPC, wrPC, wrTarget;
  logic [1:0]  wrCtrlType;
  logic [2:0]  updCount;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  typ;
    logic        dir;
  } upd_t;

  upd_t sb[$];
  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int base;

  always #5 clk = ~clk;

  btb_update_arbiter dut (
    .clk(clk), .reset(rst_n),
    .updateEn_i(updateEn), .updatePC_i(updatePC), .updateTargetAddr_i(updateTgt),
    .updateCtrlType_i(updateType), .updateDir_i(updateDir),
    .fetchReq_i(fetchReq), .fetchPC_i(fetchPC),
    .fetchGrant_o(fetchGrant), .btbRdEn_o(btbRdEn), .btbRdPC_o(btbRdPC),
    .btbWrEn_o(btbWrEn), .bpWrEn_o(bpWrEn), .wrPC_o(wrPC), .wrTarget_o(wrTarget),
    .wrCtrlType_o(wrCtrlType), .wrDir_o(wrDir),
    .updFull_o(updFull), .updDrop_o(updDrop), .updCount_o(updCount)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [1:0] typ, input logic dir, input logic freq, input logic [31:0] fpc);
    upd_t e;
    updateEn = en; updatePC = pc; updateTgt = tgt; updateType = typ; updateDir = dir;
    fetchReq = freq; fetchPC = fpc;
    if (en) begin
      e.pc = pc; e.tgt = tgt; e.typ = typ; e.dir = dir;
      sb.push_back(e);
    end
  endtask

  task automatic sample();
    upd_t e;
    @(negedge clk);
    if (rst_n) begin
      if (btbWrEn || bpWrEn) begin
        n_wr++;
        if (sb.size() == 0) chk("unexp_wr", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wr_pc", wrPC, e.pc);
          chk("wr_tgt", wrTarget, e.tgt);
          chk("wr_type", wrCtrlType, e.typ);
          chk("wr_dir", wrDir, e.dir);
          chk("btb_we", btbWrEn, (e.typ != 2'b11) || e.dir);
          chk("bp_we", bpWrEn, e.typ == 2'b11);
        end
      end
      chk("drop", updDrop, 0);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h123);
    updateEn = 1'b1;
    #3;
    chk("rst_grant", fetchGrant, 0);
    chk("rst_rden", btbRdEn, 0);
    chk("rst_rdpc", btbRdPC, 0);
    chk("rst_we", {btbWrEn, bpWrEn, updDrop, updFull}, 0);
    chk("rst_count", updCount, 0);
    updateEn = 1'b0;
    adv();
    rst_n = 1'b1;

    // fetch-only lookups
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h1000 + 32'(i * 4));
      sample();
      chk("f_grant", fetchGrant, 1);
      chk("f_rden", btbRdEn, 1);
      chk("f_rdpc", btbRdPC, 32'h1000 + 32'(i * 4));
      chk("f_we", {btbWrEn, bpWrEn}, 0);
      chk("f_count", updCount, 0);
      adv();
    end

    // single update with fetch idle
    base = n_wr;
    drive(1'b1, 32'h400, 32'h800, 2'b11, 1'b1, 1'b0, 32'h0);
    sample();
    chk("s_lat0", n_wr, base + BYP);
    adv();
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    sample();
    chk("s_lat1", n_wr, base + 1);
    chk("s_count1", updCount, 1 - BYP);
    adv();
    sample();
    chk("s_count2", updCount, 0);
    adv();

    // starvation: 8 denied cycles then a forced slot
    base = n_wr;
    drive(1'b1, 32'h500, 32'h900, 2'b10, 1'b1, 1'b1, 32'h2000);
    sample();
    chk("st_grant0", fetchGrant, 1);
    adv();
    updateEn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("st_deny_grant", fetchGrant, 1);
      chk("st_deny_nowr", n_wr, base);
      adv();
    end
    sample();
    chk("st_force_grant", fetchGrant, 0);
    chk("st_force_wr", n_wr, base + 1);
    adv();
    sample();
    chk("st_after_grant", fetchGrant, 1);
    chk("st_after_count", updCount, 0);
    adv();

    // five back-to-back updates under continuous fetch
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 16), 32'h7000 + 32'(i * 16), 2'(i), 1'(i), 1'b1, 32'h4000);
      sample();
      if (i == 4) begin
        chk("bb_full", updFull, 1);
        chk("bb_count", updCount, 4);
        chk("bb_force", fetchGrant, 0);
      end else begin
        chk("bb_grant", fetchGrant, 1);
      end
      adv();
    end
    updateEn = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      sample();
      adv();
    end
    chk("bb_drained", sb.size(), 0);
    sample();
    chk("bb_count_end", updCount, 0);
    chk("bb_full_end", updFull, 0);
    adv();

    // write-enable decode: conditional not-taken, then return
    base = n_wr;
    drive(1'b1, 32'h600, 32'hA00, 2'b11, 1'b0, 1'b0, 32'h0);
    sample();
    adv();
    drive(1'b1, 32'h604, 32'hA04, 2'b00, 1'b0, 1'b0, 32'h0);
    sample();
    adv();
    updateEn = 1'b0;
    repeat (3) begin
      sample();
      adv();
    end
    chk("dec_writes", n_wr, base + 2);

    // reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hB00 + 32'(i * 4), 32'hC00, 2'b01, 1'b1, 1'b1, 32'h5000);
      sample();
      adv();
    end
    updateEn = 1'b0;
    chk("pre_rst_count", updCount, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", updCount, 0);
    chk("mid_rst_grant", fetchGrant, 0);
    chk("mid_rst_we", {btbWrEn, bpWrEn}, 0);
    sb.delete();
    adv();
    rst_n = 1'b1;
    fetchReq = 1'b0;
    base = n_wr;
    repeat (12) begin
      sample();
      adv();
    end
    chk("post_rst_nowr", n_wr, base);
    chk("post_rst_count", updCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_update_arbiter.md
Name: btb_update_arbiter

Overview:
Shares the single-ported BTB / direction-predictor array between front-end lookups and the branch-resolution updates emitted by the CTI queue (updatePC/updateTargetAddr/updateCtrlType/updateDir/updateEn).
Buffers updates in a small FIFO and grants the array port each cycle. Fetch has priority; a starvation counter and FIFO-full condition force an update slot.
Sits between the CTI queue and the BTB, and alongside fetch stage 1.

Parameters:
SIZE_PC, 32, PC / target width
BRANCH_TYPE, 2, control-type width (2'b00 return, 2'b01 call, 2'b10 jump, 2'b11 conditional)
QDEPTH, 4, update FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, max consecutive cycles a non-empty FIFO may be denied the port

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
updateEn_i  in  1  update request from CTI queue
updatePC_i  in  SIZE_PC  branch PC
updateTargetAddr_i  in  SIZE_PC  resolved target
updateCtrlType_i  in  BRANCH_TYPE  control type
updateDir_i  in  1  resolved direction (1 = taken)
fetchReq_i  in  1  fetch stage 1 requests a lookup this cycle
fetchPC_i  in  SIZE_PC  lookup PC
fetchGrant_o  out  1  lookup performed this cycle; fetch must stall when low with fetchReq_i high
btbRdEn_o  out  1  array read enable
btbRdPC_o  out  SIZE_PC  array read address
btbWrEn_o  out  1  BTB entry write
bpWrEn_o  out  1  direction-counter write
wrPC_o  out  SIZE_PC  write PC
wrTarget_o  out  SIZE_PC  write target
wrCtrlType_o  out  BRANCH_TYPE  write control type
wrDir_o  out  1  write direction
updFull_o  out  1  FIFO full (registered)
updDrop_o  out  1  one-cycle pulse: update lost because FIFO full
updCount_o  out  log2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers 0, starve counter 0. All outputs 0 except updCount_o=0. A reset mid-operation discards pending updates.
- FIFO: enqueue on updateEn_i when count<QDEPTH, or when count==QDEPTH and a dequeue happens the same cycle. Otherwise updDrop_o=1 for that cycle and the update is lost. FIFO order is preserved. Pointers wrap modulo QDEPTH.
- force = ~empty & (full | starve==STARVE_LIMIT).
- service = ~empty & (~fetchReq_i | force).
- fetchGrant_o = btbRdEn_o = fetchReq_i & ~service. btbRdPC_o = fetchPC_i when granted, else 0.
- On service (combinational from FIFO head, dequeue at the clock edge):
  - bpWrEn_o=1 iff head type==2'b11.
  - btbWrEn_o=1 iff head type!=2'b11, or head dir==1.
  - wr* outputs = head fields when service=1, else 0.
- Starve counter: increments (saturating at STARVE_LIMIT) when ~empty & fetchReq_i & ~service. Clears on service or when the FIFO is empty.
- Update latency: minimum 1 cycle from updateEn_i to write. Worst case is STARVE_LIMIT+1 cycles per entry ahead of it.
- updCount_o = count; updFull_o = (count==QDEPTH). Both reflect registered state.
- Simultaneous enqueue+dequeue leaves count unchanged.

Optional Feature:
BTB_UPD_BYPASS_EN
- Defined: when the FIFO is empty, updateEn_i=1 and fetchReq_i=0, the incoming update is written in the same cycle (0-cycle latency) and not enqueued. Same write-enable rules apply.
- Undefined: every update goes through the FIFO.

Test Plan:
- Reset with reset=0 then release; 3 cycles with fetchReq_i=1 -> fetchGrant_o=1 each cycle, btbRdPC_o=fetchPC_i, all write enables 0, updCount_o=0.
- Single update (PC 0x400, target 0x800, type 2'b11, dir 1) with fetchReq_i=0 -> next cycle bpWrEn_o=1, btbWrEn_o=1, wrPC_o=0x400, wrTarget_o=0x800; count returns to 0. With BTB_UPD_BYPASS_EN the write occurs in the same cycle.
- One update, then fetchReq_i held 1 -> 8 denied cycles, then on cycle 9 fetchGrant_o=0 and the write occurs; starve counter clears.
- 5 back-to-back updates with fetchReq_i=1, QDEPTH=4 -> updFull_o after the 4th. On the 5th, force is active so a dequeue occurs and the 5th is accepted; updDrop_o stays 0.
- Type 2'b11, dir 0 update -> bpWrEn_o=1, btbWrEn_o=0. Type 2'b00 return -> btbWrEn_o=1, bpWrEn_o=0.
- Assert reset with 3 entries queued -> count=0 immediately. After release, no writes are issued.
